// File: rtl/uart_boot_loader_if.sv
// UART boot loader bus bundle: byte link, RAM write port and status.
// master = loader side, slave = UART/RAM/CPU side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              transmit;
  logic              tx_done;
  logic              trigger;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              booting;
  logic              cpu_rst;
  logic [ADDR_W-1:0] byte_count;
  logic [1:0]        err;

  modport master (
    input  rx_data, rx_done, tx_done, trigger,
    output tx_data, transmit, ram_addr, ram_data,
    output ram_we, booting, cpu_rst, byte_count, err
  );

  modport slave (
    output rx_data, rx_done, tx_done, trigger,
    input  tx_data, transmit, ram_addr, ram_data,
    input  ram_we, booting, cpu_rst, byte_count, err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART image loader: sync, 16-bit length, payload, checksum.
// Writes payload to RAM, echoes, ACK/NAK, holds CPU in reset.
module uart_boot_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          BASE_ADDR = 0,
  parameter int          MAX_BYTES = 8192,
  parameter int          ECHO      = 1,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  uart_boot_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_HUNT, S_LEN_LO, S_LEN_HI, S_DATA, S_ECHO_WAIT,
    S_CSUM, S_RESP, S_RESP_WAIT, S_DONE
  } state_t;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              last_q, last_d;
  logic [7:0]        resp_q, resp_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              transmit_q, transmit_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              ram_we_q, ram_we_d;
  logic              booting_q, booting_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic        clr, timed, ev, to_hit, lastb;
  logic [15:0] len_nx;

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    last_d     = last_q;
    resp_d     = resp_q;
    err_d      = err_q;
    tx_data_d  = tx_data_q;
    transmit_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    clr        = 1'b0;
    len_nx     = {bus.rx_data, len_q[7:0]};
    lastb      = (32'(cnt_q) + 32'd1) == 32'(len_q);
    ev         = bus.rx_done | bus.tx_done;
    timed      = (state_q != S_HUNT) && (state_q != S_DONE);
    tmo_d      = (timed && !ev) ? tmo_q + 32'd1 : 32'd0;
    to_hit     = (TIMEOUT != 0) && timed && !ev &&
                 (tmo_q + 32'd1 == TIMEOUT);

    if (bus.trigger) begin
      state_d = S_HUNT;
      clr     = 1'b1;
    end else if (to_hit) begin
      state_d = S_HUNT;
      err_d   = 2'd3;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          if (bus.rx_done && bus.rx_data == SYNC_BYTE)
            state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (bus.rx_done) begin
            len_d[7:0] = bus.rx_data;
            state_d    = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (bus.rx_done) begin
            len_d = len_nx;
            if (len_nx == 16'd0 || 32'(len_nx) > MAX_BYTES) begin
              err_d   = 2'd2;
              resp_d  = NAK;
              state_d = S_RESP;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          // a byte right behind a write is dropped to keep ram_we single
          if (bus.rx_done && !ram_we_q) begin
            ram_we_d   = 1'b1;
            ram_data_d = bus.rx_data;
            ram_addr_d = BASE + cnt_q;
            sum_d      = sum_q + bus.rx_data;
            cnt_d      = cnt_q + 1'b1;
            last_d     = lastb;
            if (ECHO != 0) begin
              transmit_d = 1'b1;
              tx_data_d  = bus.rx_data;
              state_d    = S_ECHO_WAIT;
            end else if (lastb) begin
              state_d = S_CSUM;
            end
          end
        end
        S_ECHO_WAIT: begin
          if (bus.rx_done) begin
            err_d   = 2'd1;
            resp_d  = NAK;
            state_d = S_RESP;
          end else if (bus.tx_done) begin
            state_d = last_q ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (bus.rx_done) begin
            if (8'(sum_q + bus.rx_data) == 8'h00) begin
              resp_d = ACK;
            end else begin
              resp_d = NAK;
              err_d  = 2'd1;
            end
            state_d = S_RESP;
          end
        end
        S_RESP: begin
          transmit_d = 1'b1;
          tx_data_d  = resp_q;
          state_d    = S_RESP_WAIT;
        end
        S_RESP_WAIT: begin
          if (bus.tx_done) begin
            if (resp_q == ACK) begin
              err_d   = 2'd0;
              state_d = S_DONE;
            end else begin
              clr     = 1'b1;
              state_d = S_HUNT;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_HUNT;
      endcase
    end

    if (clr) begin
      cnt_d      = '0;
      sum_d      = 8'h00;
      ram_addr_d = BASE;
      tmo_d      = 32'd0;
    end

    booting_d = (state_d != S_DONE);
    cpu_rst_d = booting_d | booting_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      len_q      <= 16'd0;
      cnt_q      <= '0;
      sum_q      <= 8'h00;
      last_q     <= 1'b0;
      resp_q     <= 8'h00;
      err_q      <= 2'd0;
      tmo_q      <= 32'd0;
      tx_data_q  <= 8'h00;
      transmit_q <= 1'b0;
      ram_addr_q <= BASE;
      ram_data_q <= 8'h00;
      ram_we_q   <= 1'b0;
      booting_q  <= 1'b1;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      last_q     <= last_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      transmit_q <= transmit_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      booting_q  <= booting_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.transmit   = transmit_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.booting    = booting_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.byte_count = cnt_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a write/transmit scoreboard.
// u0: echo, base 0x100, max 16, timeout 50. u1: no echo, base 0.
module tb_uart_boot_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       trigger;
  logic       sel;
  logic       td0, td1;

  int checks = 0;
  int errors = 0;

  wr_t        wq0[$], wq1[$];
  logic [7:0] tq0[$], tq1[$];
  logic [7:0] pl [0:15];
  logic [15:0] last_wa0;

  uart_boot_loader_if #(.ADDR_W(16)) b0 ();
  uart_boot_loader_if #(.ADDR_W(16)) b1 ();

  assign b0.rx_data = rx_data;
  assign b0.rx_done = rx_done & ~sel;
  assign b0.trigger = trigger & ~sel;
  assign b0.tx_done = td0;
  assign b1.rx_data = rx_data;
  assign b1.rx_done = rx_done & sel;
  assign b1.trigger = trigger & sel;
  assign b1.tx_done = td1;

  uart_boot_loader #(
    .ADDR_W(16), .BASE_ADDR(16'h100), .MAX_BYTES(16),
    .ECHO(1), .SYNC_BYTE(8'hA5), .TIMEOUT(50)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  uart_boot_loader #(
    .ADDR_W(16), .BASE_ADDR(0), .MAX_BYTES(8192),
    .ECHO(0), .SYNC_BYTE(8'hA5), .TIMEOUT(0)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic see_wr(input int s, input logic [15:0] a,
                        input logic [7:0] d);
    wr_t w;
    int  n;
    n = (s == 0) ? wq0.size() : wq1.size();
    checks++;
    assert (n != 0) else begin
      errors++;
      $error("FAIL u%0d_wr_unexpected observed=%h/%h expected=none",
             s, a, d);
    end
    if (n != 0) begin
      w = (s == 0) ? wq0.pop_front() : wq1.pop_front();
      checks++;
      assert (a === w.a && d === w.d) else begin
        errors++;
        $error("FAIL u%0d_wr observed=%h/%h expected=%h/%h",
               s, a, d, w.a, w.d);
      end
    end
  endtask

  task automatic see_tx(input int s, input logic [7:0] d);
    logic [7:0] e;
    int         n;
    n = (s == 0) ? tq0.size() : tq1.size();
    checks++;
    assert (n != 0) else begin
      errors++;
      $error("FAIL u%0d_tx_unexpected observed=%h expected=none", s, d);
    end
    if (n != 0) begin
      e = (s == 0) ? tq0.pop_front() : tq1.pop_front();
      checks++;
      assert (d === e) else begin
        errors++;
        $error("FAIL u%0d_tx observed=%h expected=%h", s, d, e);
      end
    end
  endtask

  // UART tx model (tx_done 3 cycles after transmit) and output monitor
  task automatic mon();
    int d0 = 0;
    int d1 = 0;
    forever begin
      @(negedge clk);
      td0 = (d0 == 1);
      td1 = (d1 == 1);
      if (d0 > 0) d0--;
      if (d1 > 0) d1--;
      if (b0.transmit) begin
        d0 = 3;
        see_tx(0, b0.tx_data);
      end
      if (b1.transmit) begin
        d1 = 3;
        see_tx(1, b1.tx_data);
      end
      if (b0.ram_we) begin
        last_wa0 = b0.ram_addr;
        see_wr(0, b0.ram_addr, b0.ram_data);
      end
      if (b1.ram_we) see_wr(1, b1.ram_addr, b1.ram_data);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    if (sel) wq1.push_back(w);
    else     wq0.push_back(w);
  endtask

  task automatic push_tx(input logic [7:0] d);
    if (sel) tq1.push_back(d);
    else     tq0.push_back(d);
  endtask

  task automatic rxb(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic trig();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((wq0.size() + wq1.size() + tq0.size() + tq1.size()) != 0
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [7:0] csum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + pl[i];
    return 8'(8'h00 - s);
  endfunction

  task automatic frame(input int n, input logic [7:0] cs,
                       input logic [7:0] resp, input logic [15:0] base);
    logic [31:0] nn;
    nn = n;
    rxb(8'hA5);
    rxb(nn[7:0]);
    rxb(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      push_wr(16'(base + i), pl[i]);
      if (!sel) push_tx(pl[i]);
      rxb(pl[i]);
    end
    push_tx(resp);
    rxb(cs);
    drain();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_booting"}, b0.booting, 1);
    chk({tag, "_cpu_rst"}, b0.cpu_rst, 1);
    chk({tag, "_transmit"}, b0.transmit, 0);
    chk({tag, "_ram_we"}, b0.ram_we, 0);
    chk({tag, "_tx_data"}, b0.tx_data, 0);
    chk({tag, "_ram_data"}, b0.ram_data, 0);
    chk({tag, "_ram_addr"}, b0.ram_addr, 32'h100);
    chk({tag, "_byte_count"}, b0.byte_count, 0);
    chk({tag, "_err"}, b0.err, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    trigger  = 1'b0;
    sel      = 1'b0;
    td0      = 1'b0;
    td1      = 1'b0;
    last_wa0 = 16'h0;
    fork
      mon();
    join_none

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // good 3-byte frame
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(3, 8'h9A, 8'h06, 16'h100);
    chk("t1_booting", b0.booting, 0);
    chk("t1_cpu_rst", b0.cpu_rst, 0);
    chk("t1_err", b0.err, 0);
    chk("t1_count", b0.byte_count, 3);

    // bad checksum, then recover
    trig();
    chk("t2_trig_booting", b0.booting, 1);
    chk("t2_trig_cpu_rst", b0.cpu_rst, 1);
    frame(3, 8'h9B, 8'h15, 16'h100);
    chk("t2_err", b0.err, 1);
    chk("t2_booting", b0.booting, 1);
    chk("t2_count", b0.byte_count, 0);
    frame(3, 8'h9A, 8'h06, 16'h100);
    chk("t2_ok_err", b0.err, 0);
    chk("t2_ok_booting", b0.booting, 0);

    // length bounds
    trig();
    rxb(8'hA5); rxb(8'h00);
    push_tx(8'h15);
    rxb(8'h00);
    drain();
    chk("t3_len0_err", b0.err, 2);
    rxb(8'hA5); rxb(8'h11);
    push_tx(8'h15);
    rxb(8'h00);
    drain();
    chk("t3_len17_err", b0.err, 2);
    for (int i = 0; i < 16; i++) pl[i] = 8'(i * 7 + 3);
    frame(16, csum(16), 8'h06, 16'h100);
    chk("t3_last_addr", last_wa0, 32'h10F);
    chk("t3_booting", b0.booting, 0);
    chk("t3_err", b0.err, 0);

    // inter-byte timeout
    trig();
    rxb(8'hA5); rxb(8'h05); rxb(8'h00);
    push_wr(16'h100, 8'h01); push_tx(8'h01);
    rxb(8'h01);
    push_wr(16'h101, 8'h02); push_tx(8'h02);
    rxb(8'h02);
    repeat (30) @(negedge clk);
    chk("t4_err_before", b0.err, 0);
    chk("t4_count_before", b0.byte_count, 2);
    repeat (30) @(negedge clk);
    chk("t4_err", b0.err, 3);
    chk("t4_count", b0.byte_count, 0);
    chk("t4_booting", b0.booting, 1);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(3, 8'h9A, 8'h06, 16'h100);
    chk("t4_ok_count", b0.byte_count, 3);
    chk("t4_ok_err", b0.err, 0);

    // trigger coincident with a payload byte
    trig();
    rxb(8'hA5); rxb(8'h03); rxb(8'h00);
    push_wr(16'h100, 8'h11); push_tx(8'h11);
    rxb(8'h11);
    @(negedge clk);
    rx_data = 8'h22;
    rx_done = 1'b1;
    trigger = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    trigger = 1'b0;
    chk("t5_cpu_rst", b0.cpu_rst, 1);
    chk("t5_booting", b0.booting, 1);
    chk("t5_count", b0.byte_count, 0);
    repeat (8) @(negedge clk);
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    frame(2, 8'h9B, 8'h06, 16'h100);
    chk("t5_ok_booting", b0.booting, 0);

    // noise ahead of sync
    trig();
    rxb(8'h00); rxb(8'hFF); rxb(8'h12);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(3, 8'h9A, 8'h06, 16'h100);
    chk("t6_booting", b0.booting, 0);
    chk("t6_count", b0.byte_count, 3);

    // reset mid-frame
    trig();
    rxb(8'hA5); rxb(8'h03); rxb(8'h00);
    push_wr(16'h100, 8'h11); push_tx(8'h11);
    rxb(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // no-echo instance
    sel = 1'b1;
    frame(3, 8'h9A, 8'h06, 16'h0000);
    chk("t8_booting", b1.booting, 0);
    chk("t8_cpu_rst", b1.cpu_rst, 0);
    chk("t8_err", b1.err, 0);
    chk("t8_count", b1.byte_count, 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Parametrised UART image loader and successor to the single-image fixed-size boot block. It receives a framed image over the UART byte interface (sync, length, payload, checksum), writes the payload into program RAM starting at BASE_ADDR, and optionally echoes each byte. It replies ACK or NAK, holds the CPU in reset while loading, and supports re-trigger, inter-byte timeout and length checking.

Parameters:
ADDR_W, 16, RAM address width.
BASE_ADDR, 0, first RAM address written.
MAX_BYTES, 8192, largest accepted payload; must not exceed 2^ADDR_W - BASE_ADDR.
ECHO, 1, 1 = echo each payload byte and wait for tx_done before accepting the next.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 1000000, idle clk cycles between bytes before the frame is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_data  in  8  received byte, valid while rx_done is high
rx_done  in  1  one-cycle pulse, byte received
tx_data  out  8  byte to send
transmit  out  1  one-cycle pulse, start transmission
tx_done  in  1  one-cycle pulse, transmission finished
trigger  in  1  one-cycle pulse, restart boot
ram_addr  out  ADDR_W  RAM write address
ram_data  out  8  RAM write data
ram_we  out  1  one-cycle RAM write strobe
booting  out  1  high while a load is in progress or pending
cpu_rst  out  1  CPU reset, high while booting
byte_count  out  ADDR_W  payload bytes written in the current frame
err  out  2  last result: 0 = none, 1 = checksum, 2 = length, 3 = timeout

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = S_HUNT, booting = 1, cpu_rst = 1, transmit = 0, ram_we = 0, tx_data = 0, ram_data = 0, ram_addr = BASE_ADDR, byte_count = 0, err = 0, timeout counter = 0.
- rx_done, tx_done and trigger are sampled on clk only; no asynchronous edge latches. rx_done is consumed in the same cycle it is sampled.
- States and transitions:
  - S_HUNT: on rx_done with rx_data == SYNC_BYTE, go to S_LEN_LO. Other bytes are ignored.
  - S_LEN_LO, then S_LEN_HI: capture the 16-bit length, LSB first.
  - After S_LEN_HI: if length == 0 or length > MAX_BYTES, set err = 2 and go to S_RESP with NAK (8'h15). Otherwise go to S_DATA.
  - S_DATA: on rx_done, drive ram_data = rx_data and ram_addr = BASE_ADDR + byte_count, with ram_we = 1 for exactly 1 cycle on the following cycle. The checksum accumulates rx_data modulo 256 (8-bit wrap) and byte_count increments.
  - In S_DATA with ECHO = 1: pulse transmit with tx_data = rx_data on the same cycle as ram_we, then enter S_ECHO_WAIT until tx_done. An rx_done arriving in S_ECHO_WAIT is a protocol violation: abort with NAK and err = 1.
  - When byte_count reaches length, go to S_CSUM.
  - S_CSUM: on rx_done, the frame is good if (sum + rx_data) mod 256 == 0 (two's-complement checksum). Good: ACK (8'h06). Bad: NAK, err = 1.
  - S_RESP: pulse transmit once with the response byte, then S_RESP_WAIT.
  - S_RESP_WAIT: on tx_done after an ACK, go to S_DONE. After a NAK, clear the address, count and sum, and go to S_HUNT with booting still high.
  - S_DONE: booting = 0; cpu_rst deasserts one cycle after booting falls; err = 0. Stay until trigger.
- Timeout: in every state except S_HUNT and S_DONE, the counter increments each cycle without rx_done/tx_done and clears on either. Reaching TIMEOUT sets err = 3 and returns to S_HUNT (no NAK) with address, count and sum cleared.
- trigger in any state: next cycle booting = 1, cpu_rst = 1, state = S_HUNT, counters cleared, err kept. trigger takes priority over a simultaneous rx_done.
- transmit and ram_we are never high for 2 consecutive cycles.
- ram_addr arithmetic is ADDR_W wide. The MAX_BYTES check guarantees no wrap.
- Latency: ram_we follows the payload rx_done by 1 clk, and ECHO transmit is coincident with it.

Test Plan:
- Reset, then send A5 03 00 11 22 33 9A -> writes 11/22/33 to addresses 0/1/2; echoes 11 22 33; transmits 06; booting and cpu_rst fall; err = 0.
- Same frame with checksum 9B -> no ACK; NAK 15 sent; err = 1; booting stays 1; a following good frame then loads and ACKs.
- Length 0 and length MAX_BYTES+1 -> NAK with err = 2 and no ram_we pulses. Length MAX_BYTES with BASE_ADDR = 16'h100 -> last write at 16'h100 + MAX_BYTES - 1.
- TIMEOUT = 50, stop after 2 payload bytes -> after 50 cycles, state returns to S_HUNT with err = 3 and no transmit. Restart at byte_count 0.
- trigger asserted mid-payload, coincident with rx_done -> byte not written; cpu_rst = 1; new frame loads from BASE_ADDR. ECHO = 0 run: no echo transmits, ACK only.
- Noise bytes 00 FF 12 before A5 -> ignored; frame loads normally. rst_n low mid-frame -> all outputs return to reset values on the next edge.
